pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_stage_reg_sat_counter.sv | 38 +++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // A stage can take a new beat in any state that still has a free slot.
  function automatic logic st_has_room(input logic [1:0] st);
    return (st != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-slot (main + skid) pipeline register with registered in_ready, flush and
// a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              R,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] main_q,      main_d;
  logic [DATA_W-1:0] skid_q,      skid_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;
  logic              fire;

  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid_q & out_ready;

  // slot/state next-value logic; flush overrides every handshake outcome
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = {DATA_W{1'b0}};
      skid_d  = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            main_d = in_data;
          end else if (fire) begin
            state_d = ST_EMPTY;
            main_d  = {DATA_W{1'b0}};
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path exists
          if (fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = {DATA_W{1'b0}};
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = {DATA_W{1'b0}};
          skid_d  = {DATA_W{1'b0}};
        end
      endcase
    end
    in_ready_d  = st_has_room(state_d);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!R) begin
      state_q     <= ST_EMPTY;
      main_q      <= {DATA_W{1'b0}};
      skid_q      <= {DATA_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (R),
    .clr   (cnt_clr),
    .inc   (out_valid_q & ~out_ready),
    .cnt   (stall_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and queue-model-checked bench for pipe_stage_reg (default widths plus a CNT_W=2 copy).
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_data,  out_data2;
  logic [1:0]  occ,       occ2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .cnt_clr(cnt_clr), .occ(occ), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready), .flush(flush),
    .cnt_clr(cnt_clr), .occ(occ2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] o, input logic rdy);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_occ"},   64'(occ),       64'(o));
    chk({tag, "_ready"}, 64'(in_ready),  64'(rdy));
  endtask

  logic [31:0] q[$];
  logic [15:0] exp_cnt;
  logic        m_rdy, m_acc, m_fire;

  initial begin
    // reset
    R = 1'b0;
    tick();
    tick();
    chk_out("rst", 1'b0, 32'h0, 2'd0, 1'b1);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst2_occ", 64'(occ2), 64'd0);
    chk("rst2_ready", 64'(in_ready2), 64'd1);
    chk("rst2_valid", 64'(out_valid2), 64'd0);
    chk("rst2_data", 64'(out_data2), 64'd0);
    chk("rst2_cnt", 64'(stall_cnt2), 64'd0);
    R = 1'b1;

    // streaming at one beat per cycle
    drive(1'b1, 32'hA1, 1'b1); tick(); chk_out("str1", 1'b1, 32'hA1, 2'd1, 1'b1);
    drive(1'b1, 32'hA2, 1'b1); tick(); chk_out("str2", 1'b1, 32'hA2, 2'd1, 1'b1);
    drive(1'b1, 32'hA3, 1'b1); tick(); chk_out("str3", 1'b1, 32'hA3, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 1'b1);  tick(); chk_out("str4", 1'b0, 32'h0, 2'd0, 1'b1);

    // backpressure fills the skid slot, then drains in order
    drive(1'b1, 32'h11, 1'b0); tick(); chk_out("bp1", 1'b1, 32'h11, 2'd1, 1'b1);
    drive(1'b1, 32'h22, 1'b0); tick(); chk_out("bp2", 1'b1, 32'h11, 2'd2, 1'b0);
    drive(1'b1, 32'h33, 1'b0); tick(); chk_out("bp3", 1'b1, 32'h11, 2'd2, 1'b0);
    chk("bp_cnt", 64'(stall_cnt), 64'd2);
    drive(1'b1, 32'h33, 1'b1); tick(); chk_out("bp4", 1'b1, 32'h22, 2'd1, 1'b1);
    drive(1'b1, 32'h33, 1'b1); tick(); chk_out("bp5", 1'b1, 32'h33, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 1'b1);  tick(); chk_out("bp6", 1'b0, 32'h0, 2'd0, 1'b1);

    // flush from TWO with out_ready high
    drive(1'b1, 32'h44, 1'b0); tick();
    drive(1'b1, 32'h55, 1'b0); tick(); chk_out("fl0", 1'b1, 32'h44, 2'd2, 1'b0);
    drive(1'b0, 32'h0, 1'b1); flush = 1'b1; tick(); flush = 1'b0;
    chk_out("fl1", 1'b0, 32'h0, 2'd0, 1'b1);
    drive(1'b1, 32'h66, 1'b1); tick(); chk_out("fl2", 1'b1, 32'h66, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 1'b1);  tick(); chk_out("fl3", 1'b0, 32'h0, 2'd0, 1'b1);

    // stall counter: count, clear during a stall, saturation, flush-independence
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr0", 64'(stall_cnt), 64'd0);
    drive(1'b1, 32'h77, 1'b0); tick(); drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("cnt5", 64'(stall_cnt), 64'd5);
    chk("cnt5_sat2", 64'(stall_cnt2), 64'd3);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_stall", 64'(stall_cnt), 64'd0);
    chk("clr_stall2", 64'(stall_cnt2), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("cnt6", 64'(stall_cnt), 64'd6);
    chk("cnt6_sat2", 64'(stall_cnt2), 64'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("cnt_flush", 64'(stall_cnt), 64'd7);
    chk("cnt_flush_occ", 64'(occ), 64'd0);

    // reset in TWO with a beat being offered
    drive(1'b1, 32'h88, 1'b0); tick();
    drive(1'b1, 32'h99, 1'b0); tick(); chk("r_two", 64'(occ), 64'd2);
    drive(1'b1, 32'hAA, 1'b1); R = 1'b0; tick();
    chk_out("rst_two", 1'b0, 32'h0, 2'd0, 1'b1);
    chk("rst_two_cnt", 64'(stall_cnt), 64'd0);
    R = 1'b1; drive(1'b1, 32'hBB, 1'b1); tick();
    chk_out("post_rst", 1'b1, 32'hBB, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 1'b1); tick();
    chk_out("post_rst2", 1'b0, 32'h0, 2'd0, 1'b1);

    // random traffic against a queue model
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    q.delete();
    exp_cnt = 16'd0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 55);
      in_data   = $urandom;
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      cnt_clr   = ($urandom_range(99) < 1);
      chk("rnd_occ",   64'(occ),       64'(q.size()));
      chk("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_data",  64'(out_data),  64'((q.size() > 0) ? q[0] : 32'h0));
      chk("rnd_ready", 64'(in_ready),  64'(q.size() < 2));
      chk("rnd_cnt",   64'(stall_cnt), 64'(exp_cnt));
      m_rdy  = (q.size() < 2);
      m_acc  = in_valid && m_rdy;
      m_fire = (q.size() > 0) && out_ready;
      if (cnt_clr) exp_cnt = 16'd0;
      else if ((q.size() > 0) && !out_ready && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        if (m_fire) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
